// File: rtl/reorder_buffer_if.sv
// Bus bundle between the reorder buffer and its neighbours (issue stage,
// CDB, operand lookup, register-file commit/rename ports, fetch redirect).
//   master : issue/CDB/regfile side, drives requests and sees ROB results
//   slave  : the reorder buffer itself
interface reorder_buffer_if #(
    parameter int SIZE  = 8,
    parameter int IDX_W = 3
);
    // allocation / rename
    logic                alloc_valid_in;
    logic [4:0]          alloc_rd_in;
    logic                alloc_has_dest_in;
    logic                alloc_is_branch_in;
    logic                ready_out;
    logic [IDX_W-1:0]    alloc_idx_out;
    logic                rename_valid_out;
    logic [4:0]          rename_rd_out;
    logic [IDX_W-1:0]    rename_ix_out;
    // CDB
    logic                cdb_valid_in;
    logic [IDX_W-1:0]    cdb_idx_in;
    logic [31:0]         cdb_data_in;
    logic                cdb_mispredict_in;
    logic [31:0]         cdb_target_in;
    // operand lookup
    logic [IDX_W-1:0]    q_idx1_in;
    logic [IDX_W-1:0]    q_idx2_in;
    logic [31:0]         q_data1_out;
    logic [31:0]         q_data2_out;
    logic                q_done1_out;
    logic                q_done2_out;
    // commit
    logic                we_out;
    logic [4:0]          wa_out;
    logic [31:0]         wd_out;
    logic [IDX_W-1:0]    wrob_ix_out;
    // flush / redirect
    logic                flush_out;
    logic [31:0]         redirect_pc_out;
    logic [5*SIZE-1:0]   flush_addrs_out;
    logic [SIZE-1:0]     flush_mask_out;

    modport master (
        output alloc_valid_in, alloc_rd_in, alloc_has_dest_in, alloc_is_branch_in,
        output cdb_valid_in, cdb_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
        output q_idx1_in, q_idx2_in,
        input  ready_out, alloc_idx_out, rename_valid_out, rename_rd_out, rename_ix_out,
        input  q_data1_out, q_data2_out, q_done1_out, q_done2_out,
        input  we_out, wa_out, wd_out, wrob_ix_out,
        input  flush_out, redirect_pc_out, flush_addrs_out, flush_mask_out
    );

    modport slave (
        input  alloc_valid_in, alloc_rd_in, alloc_has_dest_in, alloc_is_branch_in,
        input  cdb_valid_in, cdb_idx_in, cdb_data_in, cdb_mispredict_in, cdb_target_in,
        input  q_idx1_in, q_idx2_in,
        output ready_out, alloc_idx_out, rename_valid_out, rename_rd_out, rename_ix_out,
        output q_data1_out, q_data2_out, q_done1_out, q_done2_out,
        output we_out, wa_out, wd_out, wrob_ix_out,
        output flush_out, redirect_pc_out, flush_addrs_out, flush_mask_out
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates an entry per issued instruction, captures
// CDB results, retires the head in program order into the register file and
// squashes everything younger when a mispredicted branch retires.
// Ports:
//   clk_in  - system clock
//   rst_in  - synchronous active-low reset
//   rob     - reorder_buffer_if.slave (alloc/rename, CDB, lookup, commit, flush)
module reorder_buffer #(
    parameter int SIZE  = 8,
    parameter int IDX_W = 3
) (
    input  logic               clk_in,
    input  logic               rst_in,
    reorder_buffer_if.slave    rob
);
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(SIZE);

    // Control state (reset)
    logic [SIZE-1:0]   busy_q,   busy_d;
    logic [SIZE-1:0]   done_q,   done_d;
    logic [IDX_W-1:0]  head_q,   head_d;
    logic [IDX_W-1:0]  tail_q,   tail_d;
    logic [IDX_W:0]    count_q,  count_d;
    logic              we_q,     we_d;
    logic [4:0]        wa_q,     wa_d;
    logic [31:0]       wd_q,     wd_d;
    logic [IDX_W-1:0]  wrob_q,   wrob_d;
    logic              flush_q,  flush_d;
    logic [31:0]       redir_q,  redir_d;
    logic [SIZE-1:0]   mask_q,   mask_d;
    logic [5*SIZE-1:0] addrs_q,  addrs_d;

    // Entry payload (only meaningful while busy, so no reset needed)
    logic [SIZE-1:0]   has_dest_q;
    logic [SIZE-1:0]   is_branch_q;
    logic [SIZE-1:0]   misp_q;
    logic [4:0]        rd_q     [SIZE];
    logic [31:0]       value_q  [SIZE];
    logic [31:0]       target_q [SIZE];

    logic commit, flush_commit, ready, alloc_fire, cdb_fire;

    // Commit decision uses registered state only, so a CDB result needs one
    // extra edge before it can retire.
    assign commit       = busy_q[head_q] & done_q[head_q];
    assign flush_commit = commit & is_branch_q[head_q] & misp_q[head_q];
    // No same-cycle credit from a commit: fullness is purely count based.
    assign ready        = (count_q != FULL_CNT) & ~flush_commit;
    assign alloc_fire   = rob.alloc_valid_in & ready;
    assign cdb_fire     = rob.cdb_valid_in & busy_q[rob.cdb_idx_in] & ~flush_commit;

    always_comb begin
        busy_d  = busy_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (IDX_W+1)'(alloc_fire) - (IDX_W+1)'(commit);
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        wrob_d  = wrob_q;
        flush_d = 1'b0;
        redir_d = '0;
        mask_d  = '0;
        addrs_d = '0;

        if (cdb_fire) begin
            done_d[rob.cdb_idx_in] = 1'b1;
        end
        if (commit) begin
            busy_d[head_q] = 1'b0;
            done_d[head_q] = 1'b0;
            head_d         = head_q + IDX_W'(1);
            we_d           = has_dest_q[head_q];
            wa_d           = rd_q[head_q];
            wd_d           = value_q[head_q];
            wrob_d         = head_q;
        end
        if (alloc_fire) begin
            busy_d[tail_q] = 1'b1;
            done_d[tail_q] = 1'b0;
            tail_d         = tail_q + IDX_W'(1);
        end
        // Mispredict retire: the branch's own link write above still goes out,
        // everything younger is squashed and the pointers restart at zero.
        if (flush_commit) begin
            flush_d = 1'b1;
            redir_d = target_q[head_q];
            for (int i = 0; i < SIZE; i++) begin
                if (i != int'(head_q) && busy_q[i] && has_dest_q[i]) begin
                    mask_d[i]        = 1'b1;
                    addrs_d[5*i +: 5] = rd_q[i];
                end
            end
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            wrob_q  <= '0;
            flush_q <= 1'b0;
            redir_q <= '0;
            mask_q  <= '0;
            addrs_q <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            wrob_q  <= wrob_d;
            flush_q <= flush_d;
            redir_q <= redir_d;
            mask_q  <= mask_d;
            addrs_q <= addrs_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in && cdb_fire) begin
            value_q[rob.cdb_idx_in]  <= rob.cdb_data_in;
            target_q[rob.cdb_idx_in] <= rob.cdb_target_in;
            misp_q[rob.cdb_idx_in]   <= rob.cdb_mispredict_in;
        end
        if (rst_in && alloc_fire) begin
            rd_q[tail_q]        <= rob.alloc_rd_in;
            has_dest_q[tail_q]  <= rob.alloc_has_dest_in;
            is_branch_q[tail_q] <= rob.alloc_is_branch_in;
        end
    end

    assign rob.ready_out        = ready;
    assign rob.alloc_idx_out    = tail_q;
    assign rob.rename_valid_out = alloc_fire & rob.alloc_has_dest_in;
    assign rob.rename_rd_out    = rob.alloc_rd_in;
    assign rob.rename_ix_out    = tail_q;
    assign rob.q_data1_out      = value_q[rob.q_idx1_in];
    assign rob.q_data2_out      = value_q[rob.q_idx2_in];
    assign rob.q_done1_out      = busy_q[rob.q_idx1_in] & done_q[rob.q_idx1_in];
    assign rob.q_done2_out      = busy_q[rob.q_idx2_in] & done_q[rob.q_idx2_in];
    assign rob.we_out           = we_q;
    assign rob.wa_out           = wa_q;
    assign rob.wd_out           = wd_q;
    assign rob.wrob_ix_out      = wrob_q;
    assign rob.flush_out        = flush_q;
    assign rob.redirect_pc_out  = redir_q;
    assign rob.flush_mask_out   = mask_q;
    assign rob.flush_addrs_out  = addrs_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a queue-based program-order model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_reorder_buffer;
    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    reorder_buffer_if #(.SIZE(8), .IDX_W(3)) rob_bus ();

    reorder_buffer #(.SIZE(8), .IDX_W(3)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rob    (rob_bus)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: queue of in-flight entries, oldest first -------
    typedef struct {
        int          idx;
        logic [4:0]  rd;
        logic        hd;
        logic        br;
        logic        done;
        logic        misp;
        logic [31:0] val;
        logic [31:0] tgt;
    } ent_t;

    ent_t        mq[$];
    int          mtail = 0;
    logic        e_we = 0, e_chk = 0, e_flush = 0, e_fchk = 0;
    logic [4:0]  e_wa = 0;
    logic [31:0] e_wd = 0, e_red = 0;
    logic [2:0]  e_wrob = 0;
    logic [7:0]  e_mask = 0;
    logic [39:0] e_addrs = 0;

    function automatic logic m_ready();
        if (mq.size() == 8) return 1'b0;
        if (mq.size() > 0 && mq[0].done && mq[0].br && mq[0].misp) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_done(input int idx);
        foreach (mq[k]) if (mq[k].idx == idx) return mq[k].done;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_val(input int idx);
        foreach (mq[k]) if (mq[k].idx == idx) return mq[k].val;
        return 32'h0;
    endfunction

    always @(posedge clk_in) begin
        ent_t h;
        ent_t n;
        logic rdy, cm, fl;
        if (!rst_in) begin
            mq.delete();
            mtail = 0;
            e_we = 0; e_wa = 0; e_wd = 0; e_wrob = 0; e_chk = 1;
            e_flush = 0; e_red = 0; e_mask = 0; e_addrs = 0; e_fchk = 1;
        end else begin
            rdy = m_ready();
            cm  = (mq.size() > 0) && mq[0].done;
            fl  = 1'b0;
            e_we = 0; e_chk = 0; e_flush = 0; e_fchk = 0;
            if (cm) begin
                h = mq.pop_front();
                e_chk = 1; e_we = h.hd; e_wa = h.rd; e_wd = h.val; e_wrob = 3'(h.idx);
                fl = h.br && h.misp;
            end
            if (fl) begin
                e_flush = 1; e_fchk = 1; e_red = h.tgt; e_mask = 0; e_addrs = 0;
                foreach (mq[k]) if (mq[k].hd) begin
                    e_mask[mq[k].idx] = 1'b1;
                    e_addrs[mq[k].idx*5 +: 5] = mq[k].rd;
                end
                mq.delete();
                mtail = 0;
            end else begin
                if (rob_bus.cdb_valid_in) begin
                    foreach (mq[k]) if (mq[k].idx == int'(rob_bus.cdb_idx_in)) begin
                        n = mq[k];
                        n.done = 1; n.val = rob_bus.cdb_data_in;
                        n.misp = rob_bus.cdb_mispredict_in; n.tgt = rob_bus.cdb_target_in;
                        mq[k] = n;
                    end
                end
                if (rob_bus.alloc_valid_in && rdy) begin
                    n.idx = mtail; n.rd = rob_bus.alloc_rd_in;
                    n.hd = rob_bus.alloc_has_dest_in; n.br = rob_bus.alloc_is_branch_in;
                    n.done = 0; n.misp = 0; n.val = 0; n.tgt = 0;
                    mq.push_back(n);
                    mtail = (mtail + 1) % 8;
                end
            end
        end
    end

    // ---------------- per-cycle compare against the model ------------------
    always @(negedge clk_in) begin
        if (chk_en) begin
            logic rdy;
            rdy = m_ready();
            chk("ready", 64'(rob_bus.ready_out), 64'(rdy));
            chk("alloc_idx", 64'(rob_bus.alloc_idx_out), 64'(mtail));
            chk("rename_valid", 64'(rob_bus.rename_valid_out),
                64'(rob_bus.alloc_valid_in && rdy && rob_bus.alloc_has_dest_in));
            if (rob_bus.rename_valid_out) begin
                chk("rename_rd", 64'(rob_bus.rename_rd_out), 64'(rob_bus.alloc_rd_in));
                chk("rename_ix", 64'(rob_bus.rename_ix_out), 64'(mtail));
            end
            chk("q_done1", 64'(rob_bus.q_done1_out), 64'(m_done(int'(rob_bus.q_idx1_in))));
            chk("q_done2", 64'(rob_bus.q_done2_out), 64'(m_done(int'(rob_bus.q_idx2_in))));
            if (m_done(int'(rob_bus.q_idx1_in)))
                chk("q_data1", 64'(rob_bus.q_data1_out), 64'(m_val(int'(rob_bus.q_idx1_in))));
            if (m_done(int'(rob_bus.q_idx2_in)))
                chk("q_data2", 64'(rob_bus.q_data2_out), 64'(m_val(int'(rob_bus.q_idx2_in))));
            chk("we", 64'(rob_bus.we_out), 64'(e_we));
            chk("flush", 64'(rob_bus.flush_out), 64'(e_flush));
            if (e_chk) begin
                chk("wa", 64'(rob_bus.wa_out), 64'(e_wa));
                chk("wd", 64'(rob_bus.wd_out), 64'(e_wd));
                chk("wrob", 64'(rob_bus.wrob_ix_out), 64'(e_wrob));
            end
            if (e_fchk) begin
                chk("redirect", 64'(rob_bus.redirect_pc_out), 64'(e_red));
                chk("flush_mask", 64'(rob_bus.flush_mask_out), 64'(e_mask));
                chk("flush_addrs", 64'(rob_bus.flush_addrs_out), 64'(e_addrs));
            end
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic idle();
        rob_bus.alloc_valid_in     = 0;
        rob_bus.alloc_rd_in        = 0;
        rob_bus.alloc_has_dest_in  = 0;
        rob_bus.alloc_is_branch_in = 0;
        rob_bus.cdb_valid_in       = 0;
        rob_bus.cdb_idx_in         = 0;
        rob_bus.cdb_data_in        = 0;
        rob_bus.cdb_mispredict_in  = 0;
        rob_bus.cdb_target_in      = 0;
        rob_bus.q_idx1_in          = 0;
        rob_bus.q_idx2_in          = 0;
    endtask

    task automatic alloc(input logic [4:0] rd, input logic hd, input logic br);
        rob_bus.alloc_valid_in     = 1;
        rob_bus.alloc_rd_in        = rd;
        rob_bus.alloc_has_dest_in  = hd;
        rob_bus.alloc_is_branch_in = br;
    endtask

    task automatic cdb(input logic [2:0] idx, input logic [31:0] d,
                       input logic mp, input logic [31:0] tg);
        rob_bus.cdb_valid_in      = 1;
        rob_bus.cdb_idx_in        = idx;
        rob_bus.cdb_data_in       = d;
        rob_bus.cdb_mispredict_in = mp;
        rob_bus.cdb_target_in     = tg;
    endtask

    task automatic do_reset();
        rst_in = 0;
        idle();
        tick();
        rst_in = 1;
    endtask

    initial begin
        logic [4:0] a95;
        rst_in = 0;
        idle();
        tick();
        tick();
        rst_in = 1;
        chk_en = 1;
        #1;
        chk("rst_ready", 64'(rob_bus.ready_out), 64'd1);
        chk("rst_alloc_idx", 64'(rob_bus.alloc_idx_out), 64'd0);
        chk("rst_we", 64'(rob_bus.we_out), 64'd0);
        chk("rst_flush_mask", 64'(rob_bus.flush_mask_out), 64'd0);

        // fill, overflow attempt, wrap of tail on full-with-commit
        for (int i = 0; i < 8; i++) begin
            alloc(5'(i + 1), 1, 0);
            #1;
            chk("fill_idx", 64'(rob_bus.alloc_idx_out), 64'(i));
            tick();
        end
        alloc(5'd9, 1, 0);
        #1;
        chk("full_ready", 64'(rob_bus.ready_out), 64'd0);
        tick();
        chk("full_ready_hold", 64'(rob_bus.ready_out), 64'd0);
        cdb(3'd0, 32'h100, 0, 0);
        tick();
        rob_bus.cdb_valid_in = 0;
        #1;
        chk("full_head_done_ready", 64'(rob_bus.ready_out), 64'd0);
        tick();
        chk("wrap_we", 64'(rob_bus.we_out), 64'd1);
        chk("wrap_wa", 64'(rob_bus.wa_out), 64'd1);
        chk("wrap_wd", 64'(rob_bus.wd_out), 64'h100);
        chk("wrap_idx", 64'(rob_bus.alloc_idx_out), 64'd0);
        tick();
        rob_bus.alloc_valid_in = 0;
        for (int i = 1; i < 8; i++) begin
            cdb(3'(i), 32'h100 + 32'(i), 0, 0);
            tick();
        end
        cdb(3'd0, 32'h200, 0, 0);
        tick();
        idle();
        repeat (3) tick();

        // single alloc / CDB / commit latency
        do_reset();
        alloc(5'd5, 1, 0);
        tick();
        idle();
        cdb(3'd0, 32'h1234, 0, 0);
        tick();
        idle();
        #1;
        chk("lat_we_early", 64'(rob_bus.we_out), 64'd0);
        chk("lat_qdone", 64'(rob_bus.q_done1_out), 64'd1);
        chk("lat_qdata", 64'(rob_bus.q_data1_out), 64'h1234);
        tick();
        chk("lat_we", 64'(rob_bus.we_out), 64'd1);
        chk("lat_wa", 64'(rob_bus.wa_out), 64'd5);
        chk("lat_wd", 64'(rob_bus.wd_out), 64'h1234);
        chk("lat_wrob", 64'(rob_bus.wrob_ix_out), 64'd0);
        tick();
        chk("lat_we_after", 64'(rob_bus.we_out), 64'd0);

        // out-of-order completion, overwrite, write to idle entry
        do_reset();
        alloc(5'd10, 1, 0);
        tick();
        alloc(5'd11, 1, 0);
        tick();
        idle();
        cdb(3'd1, 32'hBB, 0, 0);
        tick();
        cdb(3'd1, 32'hB, 0, 0);
        tick();
        cdb(3'd5, 32'hDEAD, 0, 0);
        tick();
        cdb(3'd0, 32'hA, 0, 0);
        tick();
        idle();
        chk("ooo_we_wait", 64'(rob_bus.we_out), 64'd0);
        tick();
        chk("ooo_wrob0", 64'(rob_bus.wrob_ix_out), 64'd0);
        chk("ooo_wd0", 64'(rob_bus.wd_out), 64'hA);
        tick();
        chk("ooo_wrob1", 64'(rob_bus.wrob_ix_out), 64'd1);
        chk("ooo_wd1", 64'(rob_bus.wd_out), 64'hB);
        tick();

        // mispredict flush
        do_reset();
        alloc(5'd1, 1, 1);
        tick();
        alloc(5'd3, 1, 0);
        tick();
        alloc(5'd0, 0, 0);
        tick();
        idle();
        cdb(3'd0, 32'h44, 1, 32'h40);
        tick();
        alloc(5'd9, 1, 0);
        cdb(3'd1, 32'h99, 0, 0);
        #1;
        chk("fl_pend_ready", 64'(rob_bus.ready_out), 64'd0);
        chk("fl_pend_rename", 64'(rob_bus.rename_valid_out), 64'd0);
        tick();
        idle();
        rob_bus.q_idx1_in = 3'd1;
        #1;
        a95 = rob_bus.flush_addrs_out[9:5];
        chk("fl_we", 64'(rob_bus.we_out), 64'd1);
        chk("fl_wa", 64'(rob_bus.wa_out), 64'd1);
        chk("fl_flush", 64'(rob_bus.flush_out), 64'd1);
        chk("fl_redirect", 64'(rob_bus.redirect_pc_out), 64'h40);
        chk("fl_mask", 64'(rob_bus.flush_mask_out), 64'h2);
        chk("fl_addrs1", 64'(a95), 64'd3);
        chk("fl_alloc_idx", 64'(rob_bus.alloc_idx_out), 64'd0);
        chk("fl_q_done1", 64'(rob_bus.q_done1_out), 64'd0);
        tick();
        chk("fl_pulse_end", 64'(rob_bus.flush_out), 64'd0);
        alloc(5'd4, 1, 0);
        tick();
        idle();
        cdb(3'd0, 32'h55, 0, 0);
        tick();
        idle();
        tick();
        chk("post_fl_wrob", 64'(rob_bus.wrob_ix_out), 64'd0);
        tick();

        // reset overriding a busy ROB and a pending CDB write
        do_reset();
        for (int i = 0; i < 5; i++) begin
            alloc(5'(i + 20), 1, 0);
            if (i == 1) cdb(3'd0, 32'h77, 0, 0);
            else rob_bus.cdb_valid_in = 0;
            tick();
        end
        idle();
        rst_in = 0;
        alloc(5'd30, 1, 0);
        cdb(3'd1, 32'h88, 0, 0);
        tick();
        rst_in = 1;
        idle();
        rob_bus.q_idx1_in = 3'd1;
        #1;
        chk("rs_ready", 64'(rob_bus.ready_out), 64'd1);
        chk("rs_idx", 64'(rob_bus.alloc_idx_out), 64'd0);
        chk("rs_wa", 64'(rob_bus.wa_out), 64'd0);
        chk("rs_wd", 64'(rob_bus.wd_out), 64'd0);
        chk("rs_qdone", 64'(rob_bus.q_done1_out), 64'd0);
        tick();

        // mixed traffic with wrap-around and an embedded mispredict
        for (int i = 0; i < 48; i++) begin
            alloc(5'((i % 31) + 1), (i % 5) != 0, (i % 6) == 0);
            rob_bus.alloc_valid_in = (i % 4) != 3;
            if (i >= 2) cdb(3'((i * 3) % 8), 32'h1000 + 32'(i), i == 30, 32'h800 + 32'(i));
            else rob_bus.cdb_valid_in = 0;
            rob_bus.q_idx1_in = 3'(i % 8);
            rob_bus.q_idx2_in = 3'((i + 5) % 8);
            tick();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            cdb(3'(i % 8), 32'h2000 + 32'(i), 0, 0);
            rob_bus.q_idx1_in = 3'(i % 8);
            tick();
        end
        idle();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
